// File: rtl/branch_predict_ctrl_pkg.sv
// ============================================================================
// Module      : branch_predict_ctrl_pkg
// Description : Shared constants for the branch prediction controller:
//               PC source encodings, 2-bit counter states, branch opcodes,
//               default table geometry and the saturating update helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package branch_predict_ctrl_pkg;

  // Default history-table geometry
  localparam int INDEX_W_DEF = 4;
  localparam int CNT_W_DEF   = 2;

  // PC source select encodings
  localparam logic [1:0] PCSEL_SEQ      = 2'b00;  // PC+4
  localparam logic [1:0] PCSEL_PRED     = 2'b01;  // IF predicted target
  localparam logic [1:0] PCSEL_TARGET   = 2'b10;  // EX branch target
  localparam logic [1:0] PCSEL_FALLTHRU = 2'b11;  // EX_PC+4

  // Saturating counter states
  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  // Conditional branch opcodes
  localparam logic [5:0] OP_BLTZ = 6'h01;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_BLEZ = 6'h06;
  localparam logic [5:0] OP_BGTZ = 6'h07;

  // Move a counter one step toward the resolved direction, saturating at the ends
  function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
    logic [1:0] nxt;
    nxt = cnt;
    if (taken && (cnt != ST))
      nxt = cnt + 2'd1;
    else if (!taken && (cnt != SNT))
      nxt = cnt - 2'd1;
    return nxt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/branch_predict_ctrl_bht_2bit.sv
// ============================================================================
// Module      : bht_2bit
// Description : Branch history table of 2-bit saturating counters. One
//               combinational read port, one synchronous update port.
//               A same-cycle read of the entry being written returns the
//               old value.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bht_2bit
  import branch_predict_ctrl_pkg::*;
#(
  parameter int INDEX_W = INDEX_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INDEX_W-1:0] rd_idx,
  output logic [CNT_W-1:0]   rd_cnt,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_idx,
  input  logic               wr_taken
);

  localparam int DEPTH = 1 << INDEX_W;

  logic [CNT_W-1:0] r_cnt [DEPTH];

  // Counter array: all entries weakly-not-taken on reset, saturating update on resolve
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++)
        r_cnt[i] <= WNT;
    end else if (wr_en) begin
      r_cnt[wr_idx] <= sat_update(r_cnt[wr_idx], wr_taken);
    end
  end

  assign rd_cnt = r_cnt[rd_idx];

endmodule

`default_nettype wire

// File: rtl/branch_predict_ctrl.sv
// ============================================================================
// Module      : branch_predict_ctrl
// Description : Branch prediction and flush controller for the 5-stage
//               pipeline. Predicts in IF from a 2-bit BHT, tracks the
//               prediction through ID to EX, resolves against
//               Branch_hazard, selects the PC source and flushes IF/ID and
//               ID/EX on a misprediction.
//               Optional macro BRANCH_STATS_EN adds branch/mispredict
//               statistics counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_predict_ctrl
  import branch_predict_ctrl_pkg::*;
#(
  parameter int INDEX_W = INDEX_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IF_PC,
  input  logic        IF_is_branch,
  input  logic        ID_stall,
  input  logic        EX_is_branch,
  input  logic [31:0] EX_PC,
  input  logic        Branch_hazard,
  output logic [1:0]  PC_sel,
  output logic        IF_pred_taken,
  output logic        IF_ID_flush,
  output logic        ID_EX_flush,
`ifdef BRANCH_STATS_EN
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts,
`endif
  output logic        mispredict
);

  logic [CNT_W-1:0] w_rd_cnt;
  logic             w_resolve;
  logic             w_mispredict;
  logic             r_id_valid;
  logic             r_id_pred;
  logic             r_ex_valid;
  logic             r_ex_pred;
  logic             w_unused;

  // Only the word-index bits of the PCs address the table
  assign w_unused = ^{IF_PC[31:INDEX_W+2], IF_PC[1:0], EX_PC[31:INDEX_W+2], EX_PC[1:0]};

  bht_2bit #(
    .INDEX_W (INDEX_W),
    .CNT_W   (CNT_W)
  ) u_bht (
    .clk      (clk),
    .reset    (reset),
    .rd_idx   (IF_PC[INDEX_W+1:2]),
    .rd_cnt   (w_rd_cnt),
    .wr_en    (w_resolve),
    .wr_idx   (EX_PC[INDEX_W+1:2]),
    .wr_taken (Branch_hazard)
  );

  assign IF_pred_taken = IF_is_branch & w_rd_cnt[CNT_W-1];
  // A predecoded branch that EX does not decode as one is dropped silently
  assign w_resolve     = r_ex_valid & EX_is_branch;
  assign w_mispredict  = w_resolve & (Branch_hazard != r_ex_pred);
  assign mispredict    = w_mispredict;

  // PC source and flush control; a mispredict overrides the IF prediction
  always_comb begin
    PC_sel      = PCSEL_SEQ;
    IF_ID_flush = 1'b0;
    ID_EX_flush = 1'b0;
    if (w_mispredict) begin
      PC_sel      = Branch_hazard ? PCSEL_TARGET : PCSEL_FALLTHRU;
      IF_ID_flush = 1'b1;
      ID_EX_flush = 1'b1;
    end else if (IF_pred_taken) begin
      PC_sel = PCSEL_PRED;
    end
  end

  // Prediction tracking IF->ID->EX; mispredict wipes both stages and beats a stall
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_id_valid <= 1'b0;
      r_id_pred  <= 1'b0;
      r_ex_valid <= 1'b0;
      r_ex_pred  <= 1'b0;
    end else if (w_mispredict) begin
      r_id_valid <= 1'b0;
      r_ex_valid <= 1'b0;
    end else begin
      r_ex_valid <= r_id_valid & ~ID_stall;
      r_ex_pred  <= r_id_pred;
      if (!ID_stall) begin
        r_id_valid <= IF_is_branch;
        r_id_pred  <= IF_pred_taken;
      end
    end
  end

`ifdef BRANCH_STATS_EN
  logic [31:0] r_stat_branches;
  logic [31:0] r_stat_mispredicts;

  // Resolved-branch and mispredict counters, free-running with wrap
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stat_branches    <= '0;
      r_stat_mispredicts <= '0;
    end else begin
      if (w_resolve)
        r_stat_branches <= r_stat_branches + 32'd1;
      if (w_mispredict)
        r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
    end
  end

  assign stat_branches    = r_stat_branches;
  assign stat_mispredicts = r_stat_mispredicts;
`endif

endmodule

`default_nettype wire
